// File: rtl/mpu_irq_queue.sv
// mpu_irq_queue: buffers 64-bit MPU events and issues them one at a time as registered irq pulses.
// Latency: a push into an empty queue with en high produces irq two cycles later; irqs are at least 3 cycles apart.
// Backpressure: en low holds the queue; a push while full without a same-cycle pop sets sticky overflow and is
//               discarded, or overwrites the oldest entry when MPU_IRQ_DROP_OLDEST_EN is defined.
module mpu_irq_queue #(
    parameter int DEPTH = 8
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     push,
    input  logic [63:0]              push_data,
    input  logic                     en,
    input  logic                     ovf_clr,
    output logic                     irq,
    output logic [63:0]              data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        GAP  = 2'd2
    } state_t;

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    state_t        state_q, state_d;
    logic          irq_q, irq_d;
    logic [63:0]   data_q, data_d;
    logic          full_q, full_d;
    logic          ovf_q, ovf_d;
    logic          pop;
    logic          push_ok;
    logic          wr_en;
    logic          ovf_evt;

    // Issue sequencer: fire on a non-empty queue when downstream is ready, then one dead GAP cycle
    // so the downstream en (which drops one cycle after irq) is never sampled stale.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        irq_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if ((count_q != '0) && en) begin
                    state_d = FIRE;
                    pop     = 1'b1;
                    irq_d   = 1'b1;
                end
            end
            FIRE:    state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pointer, occupancy and overflow next-state; a pop frees a slot for a same-cycle push when full.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_en    = 1'b0;
        ovf_evt  = 1'b0;
        push_ok  = push && ((count_q != DEPTH_C) || pop);

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (push_ok) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else if (push) begin
            ovf_evt = 1'b1;
`ifdef MPU_IRQ_DROP_OLDEST_EN
            // Overwrite the oldest slot (wr_ptr == rd_ptr when full) and skip past it.
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
`else
            // Queue left untouched; the new event is lost.
            wr_en    = 1'b0;
`endif
        end

        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        full_d = (count_d == DEPTH_C);
        ovf_d  = ovf_evt | (ovf_q & ~ovf_clr);
        data_d = pop ? mem_q[rd_ptr_q] : data_q;
    end

    // Control and status registers, cleared asynchronously; queue contents become irrelevant on reset.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
            data_q   <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
            data_q   <= data_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    // Entry storage; no reset needed since occupancy gates every read.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign irq      = irq_q;
    assign data     = data_q;
    assign count    = count_q;
    assign full     = full_q;
    assign overflow = ovf_q;

endmodule

// File: doc/mpu_irq_queue.md
MPU_IRQ_QUEUE -- requirements
Module: mpu_irq_queue

Interface
REQ-001 The block SHALL have exactly one parameter line: DEPTH, default 8, number of queued 64-bit entries, a power of two with a minimum of 2.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Port sys_clk SHALL be: input, 1 bit, system clock.
REQ-004 Port sys_rst SHALL be: input, 1 bit, asynchronous active-high reset.
REQ-005 Port push SHALL be: input, 1 bit, MPU event valid, one entry per cycle high.
REQ-006 Port push_data SHALL be: input, 64 bits, MPU event payload.
REQ-007 Port en SHALL be: input, 1 bit, downstream interrupt stage ready (low while an irq is uncommitted).
REQ-008 Port ovf_clr SHALL be: input, 1 bit, clears the overflow flag.
REQ-009 Port irq SHALL be: output, 1 bit, registered one-cycle interrupt pulse to the downstream stage.
REQ-010 Port data SHALL be: output, 64 bits, registered payload of the last issued irq.
REQ-011 Port count SHALL be: output, log2(DEPTH)+1 bits, current occupancy.
REQ-012 Port full SHALL be: output, 1 bit, high when count==DEPTH.
REQ-013 Port overflow SHALL be: output, 1 bit, sticky; set on any push attempted while full without a same-cycle pop.

Function
REQ-014 Storage SHALL be a circular FIFO with wr_ptr/rd_ptr of log2(DEPTH) bits that wrap modulo DEPTH.
REQ-015 The FSM SHALL have states IDLE, FIRE, GAP, each held for one cycle in FIRE and GAP.
REQ-016 From IDLE, the FSM SHALL enter FIRE at the next edge iff count!=0 and en==1; otherwise it SHALL stay in IDLE.
REQ-017 On the IDLE->FIRE edge, the block SHALL load data with the head entry, advance rd_ptr (pop) and set irq=1.
REQ-018 In FIRE, irq SHALL be 1 for exactly that one cycle; FIRE SHALL then go to GAP with irq=0.
REQ-019 GAP SHALL go to IDLE unconditionally, so that en, which is low one cycle after irq, is never sampled stale; latency from push into an empty queue with en=1 to irq is 2 cycles.
REQ-020 data SHALL hold its value from the FIRE cycle until the next FIRE.
REQ-021 A push SHALL be accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle; in that case count is unchanged and overflow is not set.
REQ-022 A same-cycle push and pop with count>0 SHALL leave count unchanged; a pop never occurs when count==0.
REQ-023 A push into an empty queue SHALL NOT be issued in the same cycle; it becomes eligible the following cycle.
REQ-024 When ovf_clr and an overflow event coincide, set SHALL win.
REQ-025 count, full and overflow SHALL be registered.

Reset
REQ-026 Assertion of sys_rst SHALL immediately force irq=0, data=0, count=0, full=0, overflow=0, pointers=0 and FSM=IDLE, including mid-FIRE/GAP; queue contents are discarded.
REQ-027 Storage RAM contents SHALL NOT need reset.

Configuration
REQ-028 When macro MPU_IRQ_DROP_OLDEST_EN is defined, a push while full with no pop SHALL overwrite the oldest entry (advance both pointers, count stays DEPTH) and set overflow.
REQ-029 When MPU_IRQ_DROP_OLDEST_EN is undefined, such a push SHALL be discarded (queue unchanged) and set overflow.

Verification
REQ-030 The bench SHALL cover: push 0xDEAD_BEEF_0000_0001 into an empty queue with en=1 -> irq pulses 1 cycle exactly 2 cycles later, data=0xDEADBEEF00000001, count returns to 0.
REQ-031 The bench SHALL cover: 3 pushes with en held 0 -> count=3, no irq; en=1 for 1 cycle then 0 -> exactly one irq, count=2.
REQ-032 The bench SHALL cover: en=1 constant with 4 queued entries -> irqs spaced exactly 3 cycles apart, in FIFO order.
REQ-033 The bench SHALL cover: DEPTH=8, 9 pushes with en=0 -> full=1, overflow=1; the head is entry 0 without the macro and entry 1 with it; ovf_clr -> overflow=0.
REQ-034 The bench SHALL cover: full queue with push and pop (IDLE->FIRE) in the same cycle -> count stays 8, overflow stays 0.
REQ-035 The bench SHALL cover: sys_rst asserted during FIRE -> irq=0 immediately (asynchronously), count=0, and no irq after release until a new push.
